// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic SEL_FETCH   = 1'b0;
    localparam logic SEL_DATA    = 1'b1;
    localparam int   DEF_TMO_CYC = 15;
    localparam int   CNT_W       = 8;

endpackage

// File: rtl/mem_port_arb_wait_cnt.sv
// Wait-cycle counter for a granted memory access; tc fires on the cycle
// that completes TMO_CYC consecutive cycles without mem_ack.
module arb_wait_cnt
    import mem_port_arb_pkg::*;
#(
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one memory port between a fetch side and a data side.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is data-over-fetch.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              sel
);

    arb_state_t state_q, state_d;
    logic       grant;
    logic       pick_data;
    logic       in_gnt;
    logic       ack_hit;
    logic       cnt_en;
    logic       tmo_hit;
    logic       we_q;

`ifdef MEM_ARB_RR_EN
    // Last-served side; on a tie the other side wins.
    logic last_data;

    assign pick_data = d_req && (!i_req || (last_data == SEL_FETCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data <= SEL_FETCH;
        end else if (grant) begin
            last_data <= pick_data ? SEL_DATA : SEL_FETCH;
        end
    end
`else
    assign pick_data = d_req;
`endif

    assign in_gnt  = (state_q == GNT_I) || (state_q == GNT_D);
    assign ack_hit = in_gnt && mem_ack;
    assign cnt_en  = in_gnt && !mem_ack;
    assign mem_req = in_gnt;
    assign mem_we  = in_gnt && we_q;

    arb_wait_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant),
        .en    (cnt_en),
        .tc    (tmo_hit)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant   = 1'b1;
                    state_d = pick_data ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack || tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at grant so requesters may change them freely afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel       <= SEL_FETCH;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            i_ack   <= ack_hit && (state_q == GNT_I);
            d_ack   <= ack_hit && (state_q == GNT_D);
            i_err   <= tmo_hit && (state_q == GNT_I);
            d_err   <= tmo_hit && (state_q == GNT_D);
            if (grant) begin
                sel       <= pick_data ? SEL_DATA : SEL_FETCH;
                we_q      <= pick_data && d_we;
                mem_addr  <= pick_data ? d_addr : i_addr;
                mem_wdata <= pick_data ? d_wdata : '0;
            end
            if (ack_hit && (state_q == GNT_I)) begin
                i_rdata <= mem_rdata;
            end
            if (ack_hit && (state_q == GNT_D)) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus random transactions
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arb;

    localparam int TMO = 15;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        sel;

    int          total = 0;
    int          bad   = 0;

    // Model state: last side served (1 = data) and the expected read-data registers.
    bit          lastData = 1'b0;
    logic [31:0] expIR = '0;
    logic [31:0] expDR = '0;

    mem_port_arb #(
        .DATA_W  (32),
        .TMO_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] pulses();
        return {28'd0, i_ack, d_ack, i_err, d_err};
    endfunction

    // Winner from the arbitration rules: data on a tie unless round-robin says it was served last.
    function automatic bit pickData(input bit ir, input bit dr);
`ifdef MEM_ARB_RR_EN
        if (ir && dr) return !lastData;
`endif
        return dr;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction; ackDelay < 0 means memory never answers.
    task automatic applyStimulus(input bit ir, input bit dr, input bit we,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int ackDelay, input bit keep);
        bit          winD;
        bit          seen;
        int          cyc;
        int          doneCyc;
        logic [31:0] expAddr;
        winD     = pickData(ir, dr);
        lastData = winD;
        expAddr  = winD ? da : ia;
        doneCyc  = (ackDelay < 0) ? TMO : ackDelay + 1;
        @(posedge clk); #1;
        i_req = ir; d_req = dr; d_we = we;
        i_addr = ia; d_addr = da; d_wdata = wd;
        @(posedge clk); #1;
        cyc       = 0;
        seen      = 1'b0;
        mem_ack   = (ackDelay == 0);
        mem_rdata = (ackDelay == 0) ? rd : $urandom;
        while (!seen && cyc <= TMO + 5) begin
            @(negedge clk);
            if (pulses() != 32'd0) begin
                seen = 1'b1;
                if (ackDelay >= 0) begin
                    if (winD) expDR = rd;
                    else      expIR = rd;
                end
                checkOutput("done_cycle", 32'(cyc), 32'(doneCyc));
                checkOutput("i_ack", 32'(i_ack), 32'(!winD && ackDelay >= 0));
                checkOutput("d_ack", 32'(d_ack), 32'(winD && ackDelay >= 0));
                checkOutput("i_err", 32'(i_err), 32'(!winD && ackDelay < 0));
                checkOutput("d_err", 32'(d_err), 32'(winD && ackDelay < 0));
                checkOutput("i_rdata", i_rdata, expIR);
                checkOutput("d_rdata", d_rdata, expDR);
                checkOutput("done_mem_req", 32'(mem_req), 32'd0);
                checkOutput("done_sel", 32'(sel), 32'(winD));
            end else begin
                checkOutput("gnt_mem_req", 32'(mem_req), 32'd1);
                checkOutput("gnt_sel", 32'(sel), 32'(winD));
                checkOutput("gnt_mem_addr", mem_addr, expAddr);
                checkOutput("gnt_mem_we", 32'(mem_we), 32'(winD && we));
                if (winD) checkOutput("gnt_mem_wdata", mem_wdata, wd);
                @(posedge clk); #1;
                cyc++;
                mem_ack   = (cyc == ackDelay);
                mem_rdata = (cyc == ackDelay) ? rd : $urandom;
                i_addr    = $urandom;
                d_addr    = $urandom;
                d_wdata   = $urandom;
                d_we      = 1'($urandom_range(0, 1));
            end
        end
        checkOutput("pulse_seen", 32'(seen), 32'd1);
        mem_ack = 1'b0;
        if (!keep) begin
            @(posedge clk); #1;
            i_req = 1'b0; d_req = 1'b0;
            @(negedge clk);
            checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
            checkOutput("idle_pulses", pulses(), 32'd0);
        end
    endtask

    initial begin
        int r;
        rst_n = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_pulses", pulses(), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] stray mem_ack in IDLE");
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stray_pulses", pulses(), 32'd0);
            checkOutput("stray_mem_req", 32'(mem_req), 32'd0);
            checkOutput("stray_sel", 32'(sel), 32'(lastData));
        end
        mem_ack = 1'b0;

        $display("[TB] simultaneous requests held for four transactions");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 0, 32'h00400100 + 32'(k * 4), 32'h10010100 + 32'(k * 4),
                          32'h0, 32'h11110000 + 32'(k), k % 3, (k != 3));
        end

        $display("[TB] single fetch");
        applyStimulus(1, 0, 0, 32'h00400000, 32'h0, 32'h0, 32'h8C080004, 2, 0);

        $display("[TB] data write");
        applyStimulus(0, 1, 1, 32'h0, 32'h10010000, 32'hDEADBEEF, 32'h00000000, 1, 0);

        $display("[TB] data read then timeout");
        applyStimulus(0, 1, 0, 32'h0, 32'h10010040, 32'h0, 32'hCAFEF00D, 0, 0);
        applyStimulus(0, 1, 0, 32'h0, 32'h10010080, 32'h0, 32'h0BADF00D, -1, 0);

        $display("[TB] reset during GNT_I");
        applyStimulus(1, 0, 0, 32'h00400010, 32'h0, 32'h0, 32'h12345678, 0, 0);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h00400020;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("mid_rst_mem_addr", mem_addr, 32'd0);
        checkOutput("mid_rst_i_rdata", i_rdata, 32'd0);
        checkOutput("mid_rst_d_rdata", d_rdata, 32'd0);
        checkOutput("mid_rst_pulses", pulses(), 32'd0);
        i_req = 1'b0; mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("in_rst_pulses", pulses(), 32'd0);
        end
        mem_ack = 1'b0;
        rst_n = 1'b1;
        lastData = 1'b0; expIR = '0; expDR = '0;
        @(negedge clk);
        checkOutput("post_rst_pulses", pulses(), 32'd0);
        applyStimulus(1, 0, 0, 32'h00400030, 32'h0, 32'h0, 32'h87654321, 1, 0);

        $display("[TB] random transactions");
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(1, 3);
            applyStimulus(r[0], r[1], 1'($urandom_range(0, 1)), $urandom, $urandom,
                          $urandom, $urandom,
                          ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data and address width.
REQ-002 The block SHALL have parameter TMO_CYC, default 15, meaning max wait cycles for mem_ack before error, range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; ports are clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-004 The fetch-side ports SHALL be: i_req in 1 request; i_addr in DATA_W address; i_rdata out DATA_W read data; i_ack out 1 one-cycle done; i_err out 1 one-cycle timeout.
REQ-005 The data-side ports SHALL be: d_req in 1 request; d_we in 1 write enable; d_addr in DATA_W address; d_wdata in DATA_W write data; d_rdata out DATA_W read data; d_ack out 1 done; d_err out 1 timeout.
REQ-006 The memory-side ports SHALL be: mem_req out 1; mem_we out 1; mem_addr out DATA_W; mem_wdata out DATA_W; mem_rdata in DATA_W; mem_ack in 1.
REQ-007 The block SHALL drive sel out 1, the address/data mux select: 0 = fetch, 1 = data.

Function
REQ-008 The FSM SHALL have states IDLE, GNT_I, GNT_D, DONE.
REQ-009 In IDLE with any request high, the block SHALL pick a winner and enter GNT_I or GNT_D on the next edge; with no request it SHALL stay in IDLE.
REQ-010 Default arbitration SHALL be fixed priority, with data over fetch.
REQ-011 On grant, the block SHALL latch the winner's addr/we/wdata into internal registers; requester inputs SHALL be ignored until DONE.
REQ-012 In GNT_x, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL come from the latched registers; mem_we SHALL be 0 for fetch grants.
REQ-013 sel SHALL update only on grant and SHALL hold through DONE.
REQ-014 When mem_ack=1 in GNT_x, the block SHALL capture mem_rdata into x_rdata, pulse x_ack for exactly one cycle on the next cycle (DONE), and deassert mem_req.
REQ-015 A wait counter SHALL clear on grant and increment each GNT_x cycle without mem_ack.
REQ-016 When the counter reaches TMO_CYC, the block SHALL pulse x_err (not x_ack) in DONE and leave x_rdata unchanged.
REQ-017 DONE SHALL last one cycle, then return to IDLE; minimum transaction latency is grant cycle + ack cycle + DONE (3 cycles from request sample to x_ack).
REQ-018 A requester SHALL keep x_req high until its ack/err; after DONE, a still-high x_req SHALL be treated as a new request.
REQ-019 mem_ack outside GNT_x SHALL be ignored.
REQ-020 x_ack and x_err SHALL never both be 1, and the two sides SHALL never be acknowledged in the same cycle.

Reset
REQ-021 On rst_n low, asynchronously: state IDLE; mem_req, mem_we, sel, i_ack, d_ack, i_err, d_err = 0; mem_addr, mem_wdata, i_rdata, d_rdata, counter, and last-winner flag = 0.
REQ-022 Reset during GNT_x SHALL abandon the transaction with no ack/err issued.

Configuration
REQ-023 With macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, the side not granted last wins; the last-winner flag resets to fetch, so the first tie goes to data.
REQ-024 Without MEM_ARB_RR_EN, the block SHALL use the fixed priority of REQ-010 and SHALL not instantiate the last-winner flag.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE/GNT_I/GNT_D/DONE), SEL_FETCH=0, SEL_DATA=1, and the default TMO_CYC.
REQ-026 The timeout counter SHALL be a sub-module arb_wait_cnt (clear, enable, terminal-count out); everything else SHALL remain flat.

Verification
REQ-027 Single fetch: i_req=1, i_addr=0x00400000, mem_ack after 2 cycles with rdata=0x8C080004 -> i_ack pulse, i_rdata=0x8C080004, sel=0, mem_we=0.
REQ-028 Data write: d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr/mem_wdata match, sel=1, d_ack pulse after mem_ack.
REQ-029 Simultaneous requests held high for 4 transactions -> fixed mode: D,D,D,D; RR mode: D,I,D,I.
REQ-030 Timeout: d_req=1, mem_ack never asserted -> d_err pulse after TMO_CYC=15 wait cycles, no d_ack, d_rdata unchanged, FSM back to IDLE.
REQ-031 Reset asserted mid-GNT_I -> all outputs 0 immediately, no i_ack; after release, a new i_req completes normally.
REQ-032 Stray mem_ack=1 in IDLE -> no ack/err pulses and no state change.
